// File: rtl/arm_multicycle_controller_pkg.sv
// Shared definitions for the multicycle ARM controller: FSM state encoding,
// datapath select encodings, ALU control codes, condition codes and the
// small decode helpers used by the controller and the condition unit.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic SRCA_RD1 = 1'b0;
    localparam logic SRCA_PC  = 1'b1;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_NONE   = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Data-processing command field Funct[4:1]
    localparam logic [3:0] DP_ADD = 4'b0100;
    localparam logic [3:0] DP_SUB = 4'b0010;
    localparam logic [3:0] DP_AND = 4'b0000;
    localparam logic [3:0] DP_ORR = 4'b1100;
    localparam logic [3:0] DP_CMP = 4'b1010;
    localparam logic [3:0] DP_MOV = 4'b1101;

    typedef struct packed {
        logic [2:0] alu_ctrl;  // ALUControl to drive in EXECR/EXECI
        logic       known;     // command is one of the supported codes
        logic       is_cmp;    // compare: flags only, no register write
        logic       arith;     // ADD/SUB/CMP also produce meaningful C and V
    } dp_decode_t;

    // Decode of the data-processing command; unsupported codes fall back to
    // ADD with known=0 so the controller can squash their side effects.
    function automatic dp_decode_t dp_decode(input logic [3:0] cmd);
        dp_decode_t d;
        d = '{alu_ctrl: ALU_ADD, known: 1'b1, is_cmp: 1'b0, arith: 1'b0};
        case (cmd)
            DP_ADD: d.arith = 1'b1;
            DP_SUB: begin
                d.alu_ctrl = ALU_SUB;
                d.arith    = 1'b1;
            end
            DP_AND: d.alu_ctrl = ALU_AND;
            DP_ORR: d.alu_ctrl = ALU_ORR;
            DP_CMP: begin
                d.alu_ctrl = ALU_SUB;
                d.arith    = 1'b1;
                d.is_cmp   = 1'b1;
            end
            DP_MOV: d.alu_ctrl = ALU_MOV;
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

    // Evaluate a condition code against flags {N,Z,C,V}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arm_multicycle_controller_cond_unit.sv
// Condition unit: holds the {N,Z,C,V} flags register and the CondEx latch.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   cond            - instruction condition field
//   alu_flags       - live ALU flags {N,Z,C,V}
//   latch_condex    - capture the condition result at the end of this cycle
//   nz_we, cv_we    - update N/Z and C/V from alu_flags at the end of this cycle
//   condex          - latched condition result for the current instruction
module arm_cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       latch_condex,
    input  logic       nz_we,
    input  logic       cv_we,
    output logic       condex
);

    logic [3:0] flags_r;
    logic       condex_r;

    // Flags register; N/Z and C/V halves have independent enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= FLAGS_RST;
        end else begin
            if (nz_we) flags_r[3:2] <= alu_flags[3:2];
            if (cv_we) flags_r[1:0] <= alu_flags[1:0];
        end
    end

    // CondEx is evaluated once per instruction and held until the next decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            condex_r <= 1'b0;
        end else if (latch_condex) begin
            condex_r <= cond_eval(cond, flags_r);
        end
    end

    assign condex = condex_r;

endmodule

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM controller: Moore FSM sequencing fetch/decode/execute of
// data-processing, LDR/STR and branch instructions, with conditional
// execution through arm_cond_unit.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   Cond, Op, Funct, Rd - instruction fields
//   ALUFlags            - live ALU {N,Z,C,V}
//   PCWrite, IRWrite, RegWrite, MemWrite - storage enables (low during reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc - datapath selects
//   State               - current FSM state (debug)
module arm_multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegWrite,
    output logic [3:0] State
);

    state_t     state_r, state_next_s;
    dp_decode_t dp_s;

    logic fetch_s, irwrite_s, reg_w_s, mem_w_s, branch_s;
    logic latch_condex_s, flag_upd_s;
    logic condex_s, nz_we_s, cv_we_s, dp_no_write_s;

    assign dp_s = dp_decode(Funct[4:1]);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore control decode
    always_comb begin
        state_next_s   = ST_FETCH;
        AdrSrc         = ADR_PC;
        ResultSrc      = RES_ALUOUT;
        ALUSrcA        = SRCA_RD1;
        ALUSrcB        = SRCB_RD2;
        ALUControl     = ALU_ADD;
        fetch_s        = 1'b0;
        irwrite_s      = 1'b0;
        reg_w_s        = 1'b0;
        mem_w_s        = 1'b0;
        branch_s       = 1'b0;
        latch_condex_s = 1'b0;
        flag_upd_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                AdrSrc       = ADR_PC;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                irwrite_s    = 1'b1;
                fetch_s      = 1'b1;
                state_next_s = ST_DECODE;
            end
            ST_DECODE: begin
                ALUSrcA        = SRCA_PC;
                ALUSrcB        = SRCB_FOUR;
                ResultSrc      = RES_ALURESULT;
                latch_condex_s = 1'b1;
                case (Op)
                    OP_DP:     state_next_s = Funct[5] ? ST_EXECI : ST_EXECR;
                    OP_MEM:    state_next_s = ST_MEMADR;
                    OP_BRANCH: state_next_s = ST_BRANCH;
                    default:   state_next_s = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_EXTIMM;
                state_next_s = Funct[0] ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                AdrSrc       = ADR_RESULT;
                ResultSrc    = RES_ALUOUT;
                state_next_s = ST_MEMWB;
            end
            ST_MEMWB: begin
                ResultSrc    = RES_DATA;
                reg_w_s      = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_MEMWRITE: begin
                AdrSrc       = ADR_RESULT;
                ResultSrc    = RES_ALUOUT;
                mem_w_s      = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_EXECR: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_RD2;
                ALUControl   = dp_s.alu_ctrl;
                flag_upd_s   = 1'b1;
                state_next_s = ST_ALUWB;
            end
            ST_EXECI: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_EXTIMM;
                ALUControl   = dp_s.alu_ctrl;
                flag_upd_s   = 1'b1;
                state_next_s = ST_ALUWB;
            end
            ST_ALUWB: begin
                ResultSrc    = RES_ALUOUT;
                reg_w_s      = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_EXTIMM;
                ResultSrc    = RES_ALURESULT;
                branch_s     = 1'b1;
                state_next_s = ST_FETCH;
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // Flags move only for executed S-form supported commands; logic ops keep C/V
    assign nz_we_s = flag_upd_s & condex_s & Funct[0] & dp_s.known;
    assign cv_we_s = nz_we_s & dp_s.arith;

    // Compares and unsupported data-processing commands never write Rd
    assign dp_no_write_s = (Op == OP_DP) & (dp_s.is_cmp | ~dp_s.known);

    arm_cond_unit #(
        .FLAGS_RST (FLAGS_RST)
    ) u_cond (
        .clk          (clk),
        .reset        (reset),
        .cond         (Cond),
        .alu_flags    (ALUFlags),
        .latch_condex (latch_condex_s),
        .nz_we        (nz_we_s),
        .cv_we        (cv_we_s),
        .condex       (condex_s)
    );

    // Storage enables are forced low while reset is held
    assign PCWrite  = ~reset & (fetch_s | (branch_s & condex_s) |
                                (reg_w_s & (Rd == 4'd15) & condex_s));
    assign IRWrite  = ~reset & irwrite_s;
    assign RegWrite = ~reset & reg_w_s & condex_s & ~dp_no_write_s;
    assign MemWrite = ~reset & mem_w_s & condex_s;

    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BRANCH)};
    assign State  = state_r;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Testbench for arm_multicycle_controller: instruction-level reference model
// (state path per instruction class, condition table, flag update rules),
// a table of directed instructions, a reset-abort sequence and random traffic.
module tb_arm_multicycle_controller;
    import arm_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags, State;
    logic [1:0] Op, ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [5:0] Funct;
    logic [2:0] ALUControl;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;

    always #5 clk = ~clk;

    arm_multicycle_controller #(.FLAGS_RST(4'b0000)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite),
        .State(State)
    );

    int checks = 0;
    int failures = 0;
    logic [3:0] m_flags;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  af;
        int          len;
        int          regw;
        int          pcw;
        int          memw;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit m_cond(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !c || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // {known, cmp, arith, alu_control}
    function automatic logic [5:0] m_dp(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return {1'b1, 1'b0, 1'b1, 3'd0};
            4'b0010: return {1'b1, 1'b0, 1'b1, 3'd1};
            4'b0000: return {1'b1, 1'b0, 1'b0, 3'd2};
            4'b1100: return {1'b1, 1'b0, 1'b0, 3'd3};
            4'b1010: return {1'b1, 1'b1, 1'b1, 3'd1};
            4'b1101: return {1'b1, 1'b0, 1'b0, 3'd4};
            default: return {1'b0, 1'b0, 1'b0, 3'd0};
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle until the DUT is back in FETCH,
    // checking every cycle against the model and counting enable pulses.
    task automatic run_instr(input logic [31:0] instr, input logic [3:0] af,
                             output int len, output int regw_n, output int pcw_n, output int memw_n);
        state_t      path[5];
        int          plen;
        bit          cx, done;
        logic [5:0]  dp;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [16:0] exp, mask, act;
        state_t      st;
        Cond = instr[31:28]; Op = instr[27:26]; Funct = instr[25:20];
        Rd = instr[15:12]; ALUFlags = af;
        op = instr[27:26]; fn = instr[25:20];
        dp = m_dp(fn[4:1]);
        cx = m_cond(instr[31:28], m_flags);
        path[0] = ST_FETCH; path[1] = ST_DECODE;
        path[2] = ST_FETCH; path[3] = ST_FETCH; path[4] = ST_FETCH;
        case (op)
            2'b00: begin path[2] = fn[5] ? ST_EXECI : ST_EXECR; path[3] = ST_ALUWB; plen = 4; end
            2'b01: begin
                path[2] = ST_MEMADR;
                if (fn[0]) begin path[3] = ST_MEMREAD; path[4] = ST_MEMWB; plen = 5; end
                else begin path[3] = ST_MEMWRITE; plen = 4; end
            end
            2'b10: begin path[2] = ST_BRANCH; plen = 3; end
            default: plen = 2;
        endcase
        len = 0; regw_n = 0; pcw_n = 0; memw_n = 0; done = 1'b0;
        for (int s = 0; s < 8; s++) begin
            #1;
            if (s > 0 && State == ST_FETCH) begin
                done = 1'b1;
                break;
            end
            len++;
            st = (s < plen) ? path[s] : ST_FETCH;
            check("state", {28'd0, State}, {28'd0, st});
            exp = 17'd0;
            mask = 17'h1601F;
            exp[4:3] = op;
            exp[2:1] = {(op == 2'b01) && !fn[0], op == 2'b10};
            case (st)
                ST_FETCH: begin
                    exp[16] = 1'b1; exp[13] = 1'b1;
                    mask[15] = 1'b1; mask[12:5] = 8'hFF;
                    exp[15] = 1'b0; exp[12:11] = 2'b10; exp[10] = 1'b1; exp[9:8] = 2'b10; exp[7:5] = 3'd0;
                end
                ST_DECODE: begin
                    mask[12:5] = 8'hFF;
                    exp[12:11] = 2'b10; exp[10] = 1'b1; exp[9:8] = 2'b10; exp[7:5] = 3'd0;
                end
                ST_MEMADR: begin
                    mask[10:5] = 6'h3F;
                    exp[10] = 1'b0; exp[9:8] = 2'b01; exp[7:5] = 3'd0;
                end
                ST_MEMREAD: begin
                    mask[15] = 1'b1; mask[12:11] = 2'b11;
                    exp[15] = 1'b1; exp[12:11] = 2'b00;
                end
                ST_MEMWB: begin
                    mask[12:11] = 2'b11; exp[12:11] = 2'b01;
                    exp[0] = cx; exp[16] = cx && (instr[15:12] == 4'd15);
                end
                ST_MEMWRITE: begin
                    mask[15] = 1'b1; mask[12:11] = 2'b11;
                    exp[15] = 1'b1; exp[12:11] = 2'b00; exp[14] = cx;
                end
                ST_EXECR, ST_EXECI: begin
                    mask[10:5] = 6'h3F;
                    exp[10] = 1'b0; exp[9:8] = (st == ST_EXECI) ? 2'b01 : 2'b00; exp[7:5] = dp[2:0];
                end
                ST_ALUWB: begin
                    mask[12:11] = 2'b11; exp[12:11] = 2'b00;
                    exp[0] = cx && dp[5] && !dp[4];
                    exp[16] = cx && (instr[15:12] == 4'd15);
                end
                ST_BRANCH: begin
                    mask[12:5] = 8'hFF;
                    exp[12:11] = 2'b10; exp[10] = 1'b0; exp[9:8] = 2'b01; exp[7:5] = 3'd0;
                    exp[16] = cx;
                end
                default: ;
            endcase
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, ImmSrc, RegSrc, RegWrite};
            check("ctrl", {15'd0, act & mask}, {15'd0, exp & mask});
            regw_n += int'(RegWrite);
            pcw_n  += int'(PCWrite);
            memw_n += int'(MemWrite);
            @(negedge clk);
        end
        check("instr_returns_to_fetch", {31'd0, done}, 32'd1);
        if (op == 2'b00 && cx && fn[0] && dp[5]) begin
            m_flags[3:2] = af[3:2];
            if (dp[3]) m_flags[1:0] = af[1:0];
        end
    endtask

    task automatic run_vec(input vec_t v);
        int len, rw, pw, mw;
        run_instr(v.instr, v.af, len, rw, pw, mw);
        check({v.name, "_len"}, len, v.len);
        check({v.name, "_regw"}, rw, v.regw);
        check({v.name, "_pcw"}, pw, v.pcw);
        check({v.name, "_memw"}, mw, v.memw);
    endtask

    initial begin
        int len, rw, pw, mw;
        logic [31:0] ri;
        //          name        instr          af       len regw pcw memw
        vecs[0]  = '{"add",      32'hE0811002, 4'b1111, 4, 1, 1, 0};
        vecs[1]  = '{"ldr",      32'hE5912004, 4'b0000, 5, 1, 1, 0};
        vecs[2]  = '{"str",      32'hE5812004, 4'b0000, 4, 0, 1, 1};
        vecs[3]  = '{"subs",     32'hE0511002, 4'b0100, 4, 1, 1, 0};
        vecs[4]  = '{"beq_t",    32'h0A000002, 4'b0000, 3, 0, 2, 0};
        vecs[5]  = '{"bne_nt",   32'h1A000002, 4'b0000, 3, 0, 1, 0};
        vecs[6]  = '{"cmp",      32'hE1510002, 4'b0110, 4, 0, 1, 0};
        vecs[7]  = '{"mov_pc",   32'hE1A0F002, 4'b1001, 4, 1, 2, 0};
        vecs[8]  = '{"op11",     32'hEC000000, 4'b0000, 2, 0, 1, 0};
        vecs[9]  = '{"adds_ne",  32'h10911002, 4'b1111, 4, 0, 1, 0};
        vecs[10] = '{"unknown",  32'hE0311002, 4'b1111, 4, 0, 1, 0};
        vecs[11] = '{"orrs",     32'hE1911002, 4'b1011, 4, 1, 1, 0};
        vecs[12] = '{"cond_nv",  32'hF0811002, 4'b0000, 4, 0, 1, 0};
        vecs[13] = '{"and_imm",  32'hE2011002, 4'b0000, 4, 1, 1, 0};
        vecs[14] = '{"bmi_t",    32'h4A000002, 4'b0000, 3, 0, 2, 0};
        vecs[15] = '{"bcs_t",    32'h2A000002, 4'b0000, 3, 0, 2, 0};
        vecs[16] = '{"beq_nt",   32'h0A000002, 4'b0000, 3, 0, 1, 0};

        reset = 1'b1; Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        m_flags = 4'b0000;
        #2;
        check("rst_state", {28'd0, State}, {28'd0, ST_FETCH});
        check("rst_enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
        check("rst_fetch_sel", {25'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, 1'b0},
              {25'd0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0});
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while a store is in MEMWRITE
        run_instr(32'hE0511002, 4'b0100, len, rw, pw, mw);
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1;
        check("pre_rst_memwrite_state", {28'd0, State}, {28'd0, ST_MEMWRITE});
        check("pre_rst_memwrite", {31'd0, MemWrite}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_memwrite_drop", {31'd0, MemWrite}, 32'd0);
        check("rst_mid_state", {28'd0, State}, {28'd0, ST_FETCH});
        check("rst_mid_pcw", {30'd0, PCWrite, IRWrite}, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        m_flags = 4'b0000;
        #1;
        check("post_rst_fetch", {26'd0, State, PCWrite, IRWrite}, {26'd0, ST_FETCH, 1'b1, 1'b1});
        run_vec('{"post_rst_beq", 32'h0A000002, 4'b0000, 3, 0, 1, 0});
        run_vec('{"post_rst_bne", 32'h1A000002, 4'b0000, 3, 0, 2, 0});

        // Random instruction stream against the model
        for (int i = 0; i < 300; i++) begin
            ri = $urandom;
            if ($urandom_range(0, 1) == 0) ri[31:28] = 4'hE;
            run_instr(ri, 4'($urandom_range(0, 15)), len, rw, pw, mw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_controller.md
ARM_MULTICYCLE_CONTROLLER -- requirements
Module: arm_multicycle_controller

Interface
REQ-001 Parameter FLAGS_RST, 4'b0000, reset value of the {N,Z,C,V} flags register.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 Cond  in  4  Instr[31:28], condition field.
REQ-005 Op  in  2  Instr[27:26].
REQ-006 Funct  in  6  Instr[25:20]; [5] is I, [0] is S/L.
REQ-007 Rd  in  4  Instr[15:12].
REQ-008 ALUFlags  in  4  live ALU {N,Z,C,V}.
REQ-009 PCWrite  out  1  PC register enable.
REQ-010 AdrSrc  out  1  memory address: 0=PC, 1=Result.
REQ-011 MemWrite  out  1  data memory write enable.
REQ-012 IRWrite  out  1  instruction register enable.
REQ-013 ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
REQ-014 ALUSrcA  out  1  0=RD1 (A reg), 1=PC.
REQ-015 ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4.
REQ-016 ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV.
REQ-017 ImmSrc  out  2  00 imm8, 01 imm12, 10 branch imm24.
REQ-018 RegSrc  out  2  [0]: RA1=15; [1]: RA2=Rd.
REQ-019 RegWrite  out  1  register file write enable.
REQ-020 State  out  4  current FSM state, debug only.

Function
REQ-021 Moore FSM, states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH; one state per clock.
REQ-022 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, IRWrite=1, PCWrite=1; -> DECODE.
REQ-023 DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10; latch CondEx; Op 00&Funct[5]=0 -> EXECR, 00&Funct[5]=1 -> EXECI, 01 -> MEMADR, 10 -> BRANCH, 11 -> FETCH (no side effect).
REQ-024 MEMADR: ALUSrcA=0, ALUSrcB=01, ADD; Funct[0]=1 -> MEMREAD else MEMWRITE.
REQ-025 MEMREAD: AdrSrc=1, ResultSrc=00; -> MEMWB. MEMWB: ResultSrc=01, RegW; -> FETCH.
REQ-026 MEMWRITE: AdrSrc=1, ResultSrc=00, MemW; -> FETCH.
REQ-027 EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp; EXECI: same with ALUSrcB=01; both -> ALUWB. ALUWB: ResultSrc=00, RegW; -> FETCH.
REQ-028 BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch; -> FETCH.
REQ-029 ALUOp decode of Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP->SUB, 1101 MOV; other codes -> ADD with RegWrite and flag update suppressed; ALUOp=0 -> ADD.
REQ-030 CMP (1010) SHALL suppress RegWrite.
REQ-031 ImmSrc = Op (00 DP, 01 mem, 10 branch); RegSrc[0]=(Op==10), RegSrc[1]=(Op==01 & Funct[0]==0); held from instruction fields in all states.
REQ-032 CondEx latched in DECODE from Cond and flags register: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
REQ-033 Flags register updated at end of EXECR/EXECI only when CondEx & S: NZ when Funct[0]; CV additionally only for ADD/SUB/CMP.
REQ-034 PCWrite = FETCH | (Branch & CondEx) | (RegW & Rd==15 & CondEx); RegWrite = RegW & CondEx & !CMP; MemWrite = MemW & CondEx.
REQ-035 Failed condition: instruction still walks its full state path; no register, memory, flag or PC side effects beyond FETCH.
REQ-036 Latency: DP 4 cycles, LDR 5, STR 4, B 3, Op 11 2.

Reset
REQ-037 reset asserted: state=FETCH, flags=FLAGS_RST, CondEx=0 immediately, independent of clk.
REQ-038 While reset high, PCWrite, IRWrite, RegWrite, MemWrite SHALL be 0; other outputs show FETCH values.
REQ-039 Reset mid-instruction aborts it; first edge after deassertion performs FETCH.

Structure
REQ-040 Package arm_ctrl_pkg: state enum, ALUControl codes, ResultSrc/ALUSrcB/AdrSrc encodings, condition code constants.
REQ-041 Sub-module arm_cond_unit: flags register, condition evaluation, CondEx latch.

Verification
REQ-042 ADD R1 (0xE0811002): states FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; flags unchanged.
REQ-043 LDR (0xE5912004): 5 states; MemWrite never 1; RegWrite=1 in MEMWB with ResultSrc=01.
REQ-044 SUBS with ALUFlags=0100 then BEQ (0x0A000002): Z set; BRANCH asserts PCWrite; BNE (0x1A000002) does not.
REQ-045 CMP (0xE1510002) with ALUFlags=0110: flags become 0110; RegWrite never asserted.
REQ-046 MOV PC (Rd=15, 0xE1A0F002): PCWrite and RegWrite both 1 in ALUWB.
REQ-047 reset asserted during MEMWRITE: MemWrite drops to 0 same cycle, State=FETCH, flags=0000.
